// File: rtl/accum_adder_pipe.sv
// accum_adder_pipe: pipelined multi-operand adder tree followed by a
// wide saturating/wrapping accumulator with valid/ready flow control.
// Operands of one beat are reduced through log2(NUM_IN) registered adder
// levels; the tree result is then folded into the group accumulator.
// A result is presented only after the last beat of a group.

module accum_adder_pipe #(
   parameter int IN_WIDTH  = 18,
   parameter int NUM_IN    = 4,
   parameter int ACC_WIDTH = 40,
   parameter int SATURATE  = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [NUM_IN*IN_WIDTH-1:0]   data_i,
   input  logic                         signed_i,
   input  logic                         first_i,
   input  logic                         last_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [ACC_WIDTH-1:0]         sum_o,
   output logic                         ovf_o
);

   localparam int LVLS = $clog2(NUM_IN);
   // Tree registers are held at the final tree width; level j only ever
   // carries values that fit IN_WIDTH+j bits, so the tree never overflows.
   localparam int TW   = IN_WIDTH + LVLS;
   localparam int AW1  = ACC_WIDTH + 1;

   // Heap-ordered tree: node n sums children 2n and 2n+1. Nodes
   // NUM_IN..2*NUM_IN-1 are the extended operands, node 1 is the root.
   logic [TW-1:0]        r_node [1:NUM_IN-1];
   logic [TW-1:0]        w_val  [2:2*NUM_IN-1];

   // Beat sideband travelling alongside the tree, index 0 = level 1.
   logic [LVLS-1:0]      r_v;
   logic [LVLS-1:0]      r_sg;
   logic [LVLS-1:0]      r_f;
   logic [LVLS-1:0]      r_l;

   logic                 w_en;
   logic [TW-1:0]        w_tree;
   logic                 w_tv;
   logic                 w_tsg;
   logic                 w_tf;
   logic                 w_tl;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic                 r_mode;
   logic                 r_lastp;
   logic                 r_valid_o;

   logic                 w_fresh;
   logic                 w_mode;
   logic [AW1-1:0]       w_add;
   logic [AW1-1:0]       w_base;
   logic [AW1-1:0]       w_sum;
   logic                 w_lovf;
   logic [ACC_WIDTH-1:0] w_next;

   // Global stall: everything advances unless a result waits on downstream.
   assign w_en    = !r_valid_o || ready_i;
   assign ready_o = w_en;

   genvar g;
   for (g = 2; g < NUM_IN; g++) begin : g_int
      assign w_val[g] = r_node[g];
   end
   for (g = 0; g < NUM_IN; g++) begin : g_leaf
      assign w_val[NUM_IN+g] = {{LVLS{signed_i & data_i[g*IN_WIDTH+IN_WIDTH-1]}},
                                data_i[g*IN_WIDTH +: IN_WIDTH]};
   end

   // Adder tree levels: every node registers the sum of its two children.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 1; n < NUM_IN; n++) begin
            r_node[n] <= '0;
         end
      end else if (w_en) begin
         for (int n = 1; n < NUM_IN; n++) begin
            r_node[n] <= w_val[2*n] + w_val[2*n+1];
         end
      end
   end

   // Sideband shift register: valid, signedness and group markers per level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v  <= '0;
         r_sg <= '0;
         r_f  <= '0;
         r_l  <= '0;
      end else if (w_en) begin
         r_v[0]  <= valid_i;
         r_sg[0] <= signed_i;
         r_f[0]  <= first_i;
         r_l[0]  <= last_i;
         for (int j = 1; j < LVLS; j++) begin
            r_v[j]  <= r_v[j-1];
            r_sg[j] <= r_sg[j-1];
            r_f[j]  <= r_f[j-1];
            r_l[j]  <= r_l[j-1];
         end
      end
   end

   assign w_tree = r_node[1];
   assign w_tv   = r_v[LVLS-1];
   assign w_tsg  = r_sg[LVLS-1];
   assign w_tf   = r_f[LVLS-1];
   assign w_tl   = r_l[LVLS-1];

   // Accumulate next value: extend per group mode, add at ACC_WIDTH+1, clamp or wrap.
   always_comb begin
      w_fresh = w_tf | r_lastp;
      w_mode  = w_fresh ? w_tsg : r_mode;
      w_add   = {{(AW1-TW){w_mode & w_tree[TW-1]}}, w_tree};
      if (w_fresh) begin
         w_base = '0;
      end else begin
         w_base = {w_mode & r_acc[ACC_WIDTH-1], r_acc};
      end
      w_sum = w_base + w_add;
      if (w_mode) begin
         w_lovf = w_sum[AW1-1] ^ w_sum[AW1-2];
      end else begin
         w_lovf = w_sum[AW1-1];
      end
      if (w_lovf && (SATURATE != 0)) begin
         if (!w_mode) begin
            w_next = {ACC_WIDTH{1'b1}};
         end else if (w_sum[AW1-1]) begin
            w_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         end else begin
            w_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else begin
         w_next = w_sum[ACC_WIDTH-1:0];
      end
   end

   // Accumulator, group state and result valid; only a last beat raises valid_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_mode    <= 1'b0;
         r_lastp   <= 1'b1;
         r_valid_o <= 1'b0;
      end else if (w_en) begin
         if (w_tv) begin
            r_acc     <= w_next;
            r_ovf     <= w_fresh ? w_lovf : (r_ovf | w_lovf);
            r_mode    <= w_mode;
            r_lastp   <= w_tl;
            r_valid_o <= w_tl;
         end else begin
            r_valid_o <= 1'b0;
         end
      end
   end

   assign valid_o = r_valid_o;
   assign sum_o   = r_acc;
   assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_accum_adder_pipe.sv
// Directed self-checking bench for accum_adder_pipe: a 40-bit saturating
// instance plus 20-bit saturating and wrapping instances share stimulus.

module tb_accum_adder_pipe;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        signed_i;
   logic        first_i;
   logic        last_i;
   logic        ready_i;
   logic [71:0] data_i;

   logic        rdy_a, vo_a, ovf_a;
   logic [39:0] sum_a;
   logic        rdy_s, vo_s, ovf_s;
   logic [19:0] sum_s;
   logic        rdy_w, vo_w, ovf_w;
   logic [19:0] sum_w;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_xfer   = 0;
   int n_vhigh  = 0;
   int rise_cyc = 0;
   int pres_cyc = 0;
   logic prev_vo = 1'b0;

   logic [39:0] q_a[$];
   logic        q_ao[$];
   logic [19:0] q_s[$];
   logic        q_so[$];
   logic [19:0] q_w[$];
   logic        q_wo[$];

   accum_adder_pipe #(.IN_WIDTH(18), .NUM_IN(4), .ACC_WIDTH(40), .SATURATE(1)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(rdy_a),
      .data_i(data_i), .signed_i(signed_i), .first_i(first_i), .last_i(last_i),
      .valid_o(vo_a), .ready_i(ready_i), .sum_o(sum_a), .ovf_o(ovf_a));

   accum_adder_pipe #(.IN_WIDTH(18), .NUM_IN(4), .ACC_WIDTH(20), .SATURATE(1)) u_dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(rdy_s),
      .data_i(data_i), .signed_i(signed_i), .first_i(first_i), .last_i(last_i),
      .valid_o(vo_s), .ready_i(ready_i), .sum_o(sum_s), .ovf_o(ovf_s));

   accum_adder_pipe #(.IN_WIDTH(18), .NUM_IN(4), .ACC_WIDTH(20), .SATURATE(0)) u_dut_wrap (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(rdy_w),
      .data_i(data_i), .signed_i(signed_i), .first_i(first_i), .last_i(last_i),
      .valid_o(vo_w), .ready_i(ready_i), .sum_o(sum_w), .ovf_o(ovf_w));

   always #5 clk_i = ~clk_i;

   // Cycle counter.
   always @(posedge clk_i) cyc <= cyc + 1;

   // Output monitor: records every transferred result between edges.
   always @(negedge clk_i) begin
      prev_vo <= vo_a;
      if (vo_a) n_vhigh <= n_vhigh + 1;
      if (vo_a && !prev_vo) rise_cyc <= cyc;
      if (rst_ni && vo_a && ready_i) begin
         n_xfer <= n_xfer + 1;
         q_a.push_back(sum_a);
         q_ao.push_back(ovf_a);
      end
      if (rst_ni && vo_s && ready_i) begin
         q_s.push_back(sum_s);
         q_so.push_back(ovf_s);
      end
      if (rst_ni && vo_w && ready_i) begin
         q_w.push_back(sum_w);
         q_wo.push_back(ovf_w);
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      q_a.delete(); q_ao.delete();
      q_s.delete(); q_so.delete();
      q_w.delete(); q_wo.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic send_beat(input logic [17:0] o3, input logic [17:0] o2, input logic [17:0] o1,
                            input logic [17:0] o0, input logic sg, input logic f, input logic l);
      int n;
      data_i   = {o3, o2, o1, o0};
      signed_i = sg;
      first_i  = f;
      last_i   = l;
      valid_i  = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!rdy_a && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) check_val("accept_timeout", 64'(rdy_a), 64'd1);
      pres_cyc = cyc;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int k;
      k = 0;
      while (q_a.size() < n && k < 200) begin
         @(posedge clk_i);
         k++;
      end
      #1;
   endtask

   task automatic pop_a(input string tag, input logic [39:0] es, input logic eo);
      if (q_a.size() == 0) begin
         check_val({tag, "_cnt"}, 64'(q_a.size()), 64'd1);
      end else begin
         check_val({tag, "_sum"}, 64'(q_a.pop_front()), 64'(es));
         check_val({tag, "_ovf"}, 64'(q_ao.pop_front()), 64'(eo));
      end
   endtask

   task automatic pop_s(input string tag, input logic [19:0] es, input logic eo);
      if (q_s.size() == 0) begin
         check_val({tag, "_cnt"}, 64'(q_s.size()), 64'd1);
      end else begin
         check_val({tag, "_sum"}, 64'(q_s.pop_front()), 64'(es));
         check_val({tag, "_ovf"}, 64'(q_so.pop_front()), 64'(eo));
      end
   endtask

   task automatic pop_w(input string tag, input logic [19:0] es, input logic eo);
      if (q_w.size() == 0) begin
         check_val({tag, "_cnt"}, 64'(q_w.size()), 64'd1);
      end else begin
         check_val({tag, "_sum"}, 64'(q_w.pop_front()), 64'(es));
         check_val({tag, "_ovf"}, 64'(q_wo.pop_front()), 64'(eo));
      end
   endtask

   // Watchdog against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Directed test sequence.
   initial begin
      int x0;
      int v0;
      rst_ni   = 1'b1;
      valid_i  = 1'b0;
      data_i   = 72'd0;
      signed_i = 1'b0;
      first_i  = 1'b0;
      last_i   = 1'b0;
      ready_i  = 1'b1;
      #2 rst_ni = 1'b0;
      #10;
      check_val("rst_valid", 64'(vo_a), 64'd0);
      check_val("rst_sum",   64'(sum_a), 64'd0);
      check_val("rst_ovf",   64'(ovf_a), 64'd0);
      #11 rst_ni = 1'b1;
      #1;
      check_val("rst_ready", 64'(rdy_a), 64'd1);
      idle(2);

      // 1: single signed beat {1,2,3,-4}
      clear_q();
      x0 = n_xfer;
      v0 = n_vhigh;
      send_beat(18'h3FFFC, 18'd3, 18'd2, 18'd1, 1'b1, 1'b1, 1'b1);
      wait_out(1);
      idle(5);
      check_val("t1_latency", 64'(rise_cyc - pres_cyc), 64'd3);
      check_val("t1_pulse",   64'(n_vhigh - v0), 64'd1);
      check_val("t1_count",   64'(n_xfer - x0), 64'd1);
      pop_a("t1", 40'd2, 1'b0);

      // 2: max operands unsigned then signed
      clear_q();
      send_beat(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 1'b1);
      send_beat(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 1'b1);
      wait_out(2);
      idle(3);
      pop_a("t2u", 40'h00000FFFFC, 1'b0);
      pop_a("t2s", 40'hFFFFFFFFFC, 1'b0);

      // 3: three-beat group then a single-beat group
      clear_q();
      x0 = n_xfer;
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b1, 1'b0);
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b0, 1'b1);
      send_beat(18'd0, 18'd0, 18'd0, 18'd5, 1'b0, 1'b1, 1'b1);
      wait_out(2);
      idle(6);
      check_val("t3_count", 64'(n_xfer - x0), 64'd2);
      pop_a("t3a", 40'd12, 1'b0);
      pop_a("t3b", 40'd5, 1'b0);

      // 4: back-to-back single-beat groups with a 5-cycle downstream stall
      clear_q();
      x0 = n_xfer;
      ready_i = 1'b0;
      fork
         begin
            send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b1, 1'b1);
            send_beat(18'd2, 18'd2, 18'd2, 18'd2, 1'b0, 1'b1, 1'b1);
            send_beat(18'd3, 18'd3, 18'd3, 18'd3, 1'b0, 1'b1, 1'b1);
         end
         begin
            int k;
            k = 0;
            @(negedge clk_i);
            while (!vo_a && k < 100) begin
               @(negedge clk_i);
               k++;
            end
            check_val("t4_seen", 64'(vo_a), 64'd1);
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk_i);
               check_val("t4_stall_sum", 64'(sum_a), 64'd4);
               check_val("t4_stall_rdy", 64'(rdy_a), 64'd0);
            end
            @(posedge clk_i);
            #1;
            ready_i = 1'b1;
         end
      join
      wait_out(3);
      idle(10);
      check_val("t4_count", 64'(n_xfer - x0), 64'd3);
      pop_a("t4a", 40'd4, 1'b0);
      pop_a("t4b", 40'd8, 1'b0);
      pop_a("t4c", 40'd12, 1'b0);

      // 5: 20-bit accumulators overflow, then a clean group
      clear_q();
      send_beat(18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 1'b1, 1'b1, 1'b0);
      send_beat(18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 1'b1, 1'b0, 1'b1);
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b1, 1'b1, 1'b1);
      wait_out(2);
      idle(4);
      pop_s("t5_sat", 20'h7FFFF, 1'b1);
      pop_w("t5_wrap", 20'hFFFF8, 1'b1);
      pop_a("t5_wide", 40'd1048568, 1'b0);
      pop_s("t5_sat_clean", 20'd4, 1'b0);
      pop_w("t5_wrap_clean", 20'd4, 1'b0);
      pop_a("t5_wide_clean", 40'd4, 1'b0);

      // 6: asynchronous reset aborts a group mid-flight
      clear_q();
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b1, 1'b0);
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check_val("t6_partial_sum",   64'(sum_a), 64'd8);
      check_val("t6_partial_valid", 64'(vo_a), 64'd0);
      #3 rst_ni = 1'b0;
      #1;
      check_val("t6_rst_valid", 64'(vo_a), 64'd0);
      check_val("t6_rst_sum",   64'(sum_a), 64'd0);
      #3 rst_ni = 1'b1;
      x0 = n_xfer;
      idle(10);
      check_val("t6_no_output", 64'(n_xfer - x0), 64'd0);
      send_beat(18'd1, 18'd1, 18'd1, 18'd1, 1'b0, 1'b1, 1'b1);
      wait_out(1);
      idle(3);
      pop_a("t6_after", 40'd4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
